// File: rtl/mmm_pkg.sv
// mmm_pkg: shared fetch FSM state type and default instruction/line widths
package mmm_pkg;
   localparam int ILEN_DEF     = 32;
   localparam int LINE_LEN_DEF = 256;
   typedef enum logic [1:0] {RUN, REQ, WAIT, DRAIN} fetch_state_t;
endpackage

// File: rtl/instr_line_fetcher_line_word_mux.sv
// line_word_mux: selects one ILEN-bit instruction word from a cache line
// ports: line_i (cache line), idx_i (word index), word_o (selected word)
module line_word_mux #(
   parameter int ILEN     = 32,
   parameter int LINE_LEN = 256
) (
   input  logic [LINE_LEN-1:0]                 line_i,
   input  logic [$clog2(LINE_LEN/ILEN)-1:0]    idx_i,
   output logic [ILEN-1:0]                     word_o
);
   logic [ILEN-1:0] w_words [LINE_LEN/ILEN];
   for (genvar g = 0; g < LINE_LEN/ILEN; g++) begin : g_word
      assign w_words[g] = line_i[g*ILEN +: ILEN];
   end
   assign word_o = w_words[idx_i];
endmodule

// File: rtl/instr_line_fetcher.sv
// instr_line_fetcher: single-line instruction buffer that serves PCs from a held cache line
// ports: clk_i/rst_i (async active-high), flush_i, pc_* (fetch request), cache_req_* /
//        cache_resp_* (line fetch), instr_* (registered instruction output)
// option: INSTR_FETCH_PREFETCH_EN adds a next-line backup register filled by prefetch
module instr_line_fetcher
   import mmm_pkg::*;
#(
   parameter int ILEN     = ILEN_DEF,
   parameter int LINE_LEN = LINE_LEN_DEF,
   parameter int ADDR_LEN = 32
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   flush_i,
   input  logic                                   pc_valid_i,
   input  logic [ADDR_LEN-1:0]                    pc_i,
   output logic                                   pc_ready_o,
   output logic                                   cache_req_valid_o,
   input  logic                                   cache_req_ready_i,
   output logic [ADDR_LEN-$clog2(LINE_LEN/8)-1:0] cache_req_tag_o,
   input  logic                                   cache_resp_valid_i,
   input  logic [LINE_LEN-1:0]                    cache_resp_line_i,
   output logic                                   instr_valid_o,
   input  logic                                   instr_ready_i,
   output logic [ILEN-1:0]                        instr_o,
   output logic [ADDR_LEN-1:0]                    instr_pc_o
);
   localparam int WORD_OFF = $clog2(ILEN/8);
   localparam int LINE_OFF = $clog2(LINE_LEN/8);
   localparam int IDX_W    = LINE_OFF - WORD_OFF;
   localparam int TAG_W    = ADDR_LEN - LINE_OFF;
   fetch_state_t        r_state;
   logic [LINE_LEN-1:0] r_line;
   logic [TAG_W-1:0]    r_tag;
   logic                r_line_valid;
   logic [TAG_W-1:0]    r_req_tag;
   logic [ILEN-1:0]     r_instr;
   logic [ADDR_LEN-1:0] r_instr_pc;
   logic                r_instr_valid;
`ifdef INSTR_FETCH_PREFETCH_EN
   logic [LINE_LEN-1:0] r_bk_line;
   logic [TAG_W-1:0]    r_bk_tag;
   logic                r_bk_valid;
   logic                r_pf;
   logic                w_bk_hit;
`endif
   logic [TAG_W-1:0]    w_tag;
   logic [IDX_W-1:0]    w_idx;
   logic [ILEN-1:0]     w_word;
   logic                w_line_hit;
   logic                w_miss;
   logic                w_accept;
   assign w_tag      = pc_i[ADDR_LEN-1:LINE_OFF];
   assign w_idx      = pc_i[LINE_OFF-1:WORD_OFF];
   assign w_line_hit = r_line_valid && (r_tag == w_tag);
   assign w_miss     = pc_valid_i && !w_line_hit;
   assign pc_ready_o = (r_state == RUN) && w_line_hit && (!r_instr_valid || instr_ready_i);
   assign w_accept   = pc_valid_i && pc_ready_o;
`ifdef INSTR_FETCH_PREFETCH_EN
   assign w_bk_hit   = r_bk_valid && (r_bk_tag == w_tag);
`endif
   assign cache_req_valid_o = (r_state == REQ);
   assign cache_req_tag_o   = r_req_tag;
   assign instr_valid_o     = r_instr_valid;
   assign instr_o           = r_instr;
   assign instr_pc_o        = r_instr_pc;
   line_word_mux #(.ILEN(ILEN), .LINE_LEN(LINE_LEN)) u_mux (
      .line_i (r_line),
      .idx_i  (w_idx),
      .word_o (w_word)
   );
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state       <= RUN;
         r_line        <= '0;
         r_tag         <= '0;
         r_line_valid  <= 1'b0;
         r_req_tag     <= '0;
         r_instr       <= '0;
         r_instr_pc    <= '0;
         r_instr_valid <= 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
         r_bk_line     <= '0;
         r_bk_tag      <= '0;
         r_bk_valid    <= 1'b0;
         r_pf          <= 1'b0;
`endif
      end else begin
         if (flush_i) r_instr_valid <= 1'b0;
         else if (w_accept) begin
            r_instr       <= w_word;
            r_instr_pc    <= pc_i;
            r_instr_valid <= 1'b1;
         end else if (instr_ready_i) r_instr_valid <= 1'b0;
         if (flush_i) begin
            r_line_valid <= 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
            r_bk_valid   <= 1'b0;
`endif
            // an outstanding response must still be swallowed unless it arrives right now
            r_state <= ((r_state == WAIT || r_state == DRAIN) && !cache_resp_valid_i) ? DRAIN : RUN;
         end else begin
            case (r_state)
               RUN: begin
`ifdef INSTR_FETCH_PREFETCH_EN
                  if (w_miss && w_bk_hit) begin
                     r_line       <= r_bk_line;
                     r_tag        <= r_bk_tag;
                     r_line_valid <= 1'b1;
                     r_bk_valid   <= 1'b0;
                  end else if (w_miss) begin
                     r_state   <= REQ;
                     r_req_tag <= w_tag;
                     r_pf      <= 1'b0;
                  end else if (r_line_valid && !r_bk_valid) begin
                     r_state   <= REQ;
                     r_req_tag <= r_tag + TAG_W'(1);
                     r_pf      <= 1'b1;
                  end
`else
                  if (w_miss) begin
                     r_state   <= REQ;
                     r_req_tag <= w_tag;
                  end
`endif
               end
               REQ: if (cache_req_ready_i) r_state <= WAIT;
               WAIT: if (cache_resp_valid_i) begin
                  r_state <= RUN;
`ifdef INSTR_FETCH_PREFETCH_EN
                  if (r_pf) begin
                     r_bk_line  <= cache_resp_line_i;
                     r_bk_tag   <= r_req_tag;
                     r_bk_valid <= 1'b1;
                  end else begin
                     r_line       <= cache_resp_line_i;
                     r_tag        <= r_req_tag;
                     r_line_valid <= 1'b1;
                  end
`else
                  r_line       <= cache_resp_line_i;
                  r_tag        <= r_req_tag;
                  r_line_valid <= 1'b1;
`endif
               end
               DRAIN: if (cache_resp_valid_i) r_state <= RUN;
               default: r_state <= RUN;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_instr_line_fetcher.sv
// tb_instr_line_fetcher: directed self-checking bench for instr_line_fetcher
module tb_instr_line_fetcher;
   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         flush_i = 1'b0;
   logic         pc_valid_i = 1'b0;
   logic [31:0]  pc_i = '0;
   logic         pc_ready_o;
   logic         cache_req_valid_o;
   logic         cache_req_ready_i = 1'b1;
   logic [26:0]  cache_req_tag_o;
   logic         cache_resp_valid_i = 1'b0;
   logic [255:0] cache_resp_line_i = '0;
   logic         instr_valid_o;
   logic         instr_ready_i = 1'b1;
   logic [31:0]  instr_o;
   logic [31:0]  instr_pc_o;
   int checks = 0;
   int errors = 0;
   instr_line_fetcher dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .flush_i            (flush_i),
      .pc_valid_i         (pc_valid_i),
      .pc_i               (pc_i),
      .pc_ready_o         (pc_ready_o),
      .cache_req_valid_o  (cache_req_valid_o),
      .cache_req_ready_i  (cache_req_ready_i),
      .cache_req_tag_o    (cache_req_tag_o),
      .cache_resp_valid_i (cache_resp_valid_i),
      .cache_resp_line_i  (cache_resp_line_i),
      .instr_valid_o      (instr_valid_o),
      .instr_ready_i      (instr_ready_i),
      .instr_o            (instr_o),
      .instr_pc_o         (instr_pc_o)
   );
   always #5 clk_i = ~clk_i;
   function automatic logic [255:0] mk_line(int base);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'(base + k);
      return l;
   endfunction
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask
   task automatic test_reset();
      #3;
      checks++;
      if ({instr_valid_o, cache_req_valid_o, pc_ready_o} !== 3'b000) begin
         errors++;
         $display("FAIL reset_valids: got %b exp 000", {instr_valid_o, cache_req_valid_o, pc_ready_o});
      end
      checks++;
      if ({instr_o, instr_pc_o, cache_req_tag_o} !== '0) begin
         errors++;
         $display("FAIL reset_data: got %h/%h/%h exp 0", instr_o, instr_pc_o, cache_req_tag_o);
      end
      step();
      rst_i = 1'b0;
      step();
   endtask
   task automatic test_cold_start();
      pc_valid_i = 1'b1;
      pc_i = 32'h100;
      #1;
      checks++;
      if (pc_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL cold_ready: got %b exp 0", pc_ready_o);
      end
      step();
      checks++;
      if (cache_req_valid_o !== 1'b1 || cache_req_tag_o !== 27'h8) begin
         errors++;
         $display("FAIL cold_req: got v=%b tag=%h exp v=1 tag=8", cache_req_valid_o, cache_req_tag_o);
      end
      step();
      step();
      step();
      cache_resp_valid_i = 1'b1;
      cache_resp_line_i = mk_line(0);
      step();
      cache_resp_valid_i = 1'b0;
      checks++;
      if (pc_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL cold_hit_ready: got %b exp 1", pc_ready_o);
      end
      step();
      checks++;
      if (instr_valid_o !== 1'b1 || instr_o !== 32'd0 || instr_pc_o !== 32'h100) begin
         errors++;
         $display("FAIL cold_instr: got v=%b i=%h pc=%h exp v=1 i=0 pc=100", instr_valid_o, instr_o, instr_pc_o);
      end
   endtask
   task automatic test_back_to_back();
      logic [31:0] pcs [3] = '{32'h104, 32'h108, 32'h11C};
      logic [31:0] exp [3] = '{32'd1, 32'd2, 32'd7};
      for (int i = 0; i < 3; i++) begin
         pc_i = pcs[i];
         step();
         checks++;
         if (instr_valid_o !== 1'b1 || instr_o !== exp[i] || instr_pc_o !== pcs[i] || cache_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_%0d: got v=%b i=%h pc=%h req=%b exp v=1 i=%h pc=%h req=0",
                     i, instr_valid_o, instr_o, instr_pc_o, cache_req_valid_o, exp[i], pcs[i]);
         end
      end
   endtask
   task automatic test_stall();
      pc_i = 32'h10C;
      step();
      instr_ready_i = 1'b0;
      pc_i = 32'h110;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (pc_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready_%0d: got %b exp 0", i, pc_ready_o);
         end
         step();
         checks++;
         if (instr_valid_o !== 1'b1 || instr_o !== 32'd3 || instr_pc_o !== 32'h10C) begin
            errors++;
            $display("FAIL stall_hold_%0d: got v=%b i=%h pc=%h exp v=1 i=3 pc=10c", i, instr_valid_o, instr_o, instr_pc_o);
         end
      end
      instr_ready_i = 1'b1;
      pc_valid_i = 1'b0;
      step();
      checks++;
      if (instr_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: got %b exp 0", instr_valid_o);
      end
   endtask
   task automatic test_ignore_resp();
      cache_resp_valid_i = 1'b1;
      cache_resp_line_i = '1;
      step();
      cache_resp_valid_i = 1'b0;
      pc_valid_i = 1'b1;
      pc_i = 32'h104;
      step();
      pc_valid_i = 1'b0;
      checks++;
      if (instr_valid_o !== 1'b1 || instr_o !== 32'd1) begin
         errors++;
         $display("FAIL ignore_resp: got v=%b i=%h exp v=1 i=1", instr_valid_o, instr_o);
      end
      step();
   endtask
   task automatic test_flush_in_wait();
      pc_valid_i = 1'b1;
      pc_i = 32'h200;
      step();
      checks++;
      if (cache_req_valid_o !== 1'b1 || cache_req_tag_o !== 27'h10) begin
         errors++;
         $display("FAIL flush_req: got v=%b tag=%h exp v=1 tag=10", cache_req_valid_o, cache_req_tag_o);
      end
      step();
      flush_i = 1'b1;
      pc_valid_i = 1'b0;
      step();
      flush_i = 1'b0;
      checks++;
      if (instr_valid_o !== 1'b0 || cache_req_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_clear: got iv=%b rv=%b exp 0 0", instr_valid_o, cache_req_valid_o);
      end
      step();
      cache_resp_valid_i = 1'b1;
      cache_resp_line_i = mk_line(16);
      step();
      cache_resp_valid_i = 1'b0;
      pc_valid_i = 1'b1;
      pc_i = 32'h200;
      #1;
      checks++;
      if (pc_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL drain_discard: got %b exp 0", pc_ready_o);
      end
      pc_i = 32'h100;
      #1;
      checks++;
      if (pc_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_line_invalid: got %b exp 0", pc_ready_o);
      end
      step();
      checks++;
      if (cache_req_valid_o !== 1'b1 || cache_req_tag_o !== 27'h8) begin
         errors++;
         $display("FAIL flush_rereq: got v=%b tag=%h exp v=1 tag=8", cache_req_valid_o, cache_req_tag_o);
      end
      step();
      cache_resp_valid_i = 1'b1;
      cache_resp_line_i = mk_line(0);
      step();
      cache_resp_valid_i = 1'b0;
      pc_i = 32'h114;
      step();
      pc_valid_i = 1'b0;
      checks++;
      if (instr_valid_o !== 1'b1 || instr_o !== 32'd5) begin
         errors++;
         $display("FAIL refill_hit: got v=%b i=%h exp v=1 i=5", instr_valid_o, instr_o);
      end
      step();
   endtask
   task automatic test_reset_mid_fetch();
      pc_valid_i = 1'b1;
      pc_i = 32'h300;
      step();
      step();
      pc_valid_i = 1'b0;
      #2;
      rst_i = 1'b1;
      #1;
      checks++;
      if (cache_req_tag_o !== 27'h0 || cache_req_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got v=%b tag=%h exp v=0 tag=0", cache_req_valid_o, cache_req_tag_o);
      end
      step();
      rst_i = 1'b0;
      step();
      cache_resp_valid_i = 1'b1;
      cache_resp_line_i = mk_line(24);
      step();
      cache_resp_valid_i = 1'b0;
      pc_valid_i = 1'b1;
      #1;
      checks++;
      if (pc_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL late_resp_ignored: got %b exp 0", pc_ready_o);
      end
      step();
      pc_valid_i = 1'b0;
      checks++;
      if (cache_req_valid_o !== 1'b1 || cache_req_tag_o !== 27'h18) begin
         errors++;
         $display("FAIL post_reset_req: got v=%b tag=%h exp v=1 tag=18", cache_req_valid_o, cache_req_tag_o);
      end
   endtask
`ifdef INSTR_FETCH_PREFETCH_EN
   task automatic test_prefetch();
      pc_valid_i = 1'b1;
      pc_i = 32'h100;
      step();
      step();
      cache_resp_valid_i = 1'b1;
      cache_resp_line_i = mk_line(0);
      step();
      cache_resp_valid_i = 1'b0;
      step();
      pc_valid_i = 1'b0;
      checks++;
      if (instr_o !== 32'd0 || cache_req_valid_o !== 1'b1 || cache_req_tag_o !== 27'h9) begin
         errors++;
         $display("FAIL pf_req: got i=%h v=%b tag=%h exp i=0 v=1 tag=9", instr_o, cache_req_valid_o, cache_req_tag_o);
      end
      step();
      cache_resp_valid_i = 1'b1;
      cache_resp_line_i = mk_line(8);
      step();
      cache_resp_valid_i = 1'b0;
      pc_valid_i = 1'b1;
      pc_i = 32'h120;
      step();
      checks++;
      if (cache_req_valid_o !== 1'b0 || pc_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL pf_swap: got req=%b rdy=%b exp req=0 rdy=1", cache_req_valid_o, pc_ready_o);
      end
      step();
      checks++;
      if (instr_valid_o !== 1'b1 || instr_o !== 32'd8 || instr_pc_o !== 32'h120) begin
         errors++;
         $display("FAIL pf_instr: got v=%b i=%h pc=%h exp v=1 i=8 pc=120", instr_valid_o, instr_o, instr_pc_o);
      end
      flush_i = 1'b1;
      pc_valid_i = 1'b0;
      step();
      flush_i = 1'b0;
      pc_valid_i = 1'b1;
      pc_i = 32'hFFFF_FFE0;
      step();
      checks++;
      if (cache_req_tag_o !== 27'h7FF_FFFF) begin
         errors++;
         $display("FAIL wrap_demand: got %h exp 7ffffff", cache_req_tag_o);
      end
      step();
      cache_resp_valid_i = 1'b1;
      step();
      cache_resp_valid_i = 1'b0;
      step();
      pc_valid_i = 1'b0;
      checks++;
      if (cache_req_valid_o !== 1'b1 || cache_req_tag_o !== 27'h0) begin
         errors++;
         $display("FAIL wrap_pf: got v=%b tag=%h exp v=1 tag=0", cache_req_valid_o, cache_req_tag_o);
      end
   endtask
`endif
   initial begin
      test_reset();
`ifdef INSTR_FETCH_PREFETCH_EN
      test_prefetch();
`else
      test_cold_start();
      test_back_to_back();
      test_stall();
      test_ignore_resp();
      test_flush_in_wait();
      test_reset_mid_fetch();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
